present_sbox_layer_seq: RTL and testbench
=========================================

Name: present_sbox_layer_seq

Overview:
Parametrised, iterative PRESENT S-box layer with forward and inverse modes. It applies the 4-bit PRESENT S-box (or its inverse) to every nibble of an NIBBLES×4-bit state, using LANES S-box instances per cycle. It sits between the round-key XOR and the pLayer in area-constrained round-based encrypt/decrypt datapaths. Valid/ready handshakes on both sides let it stall against the pLayer/round controller.

Parameters:
NIBBLES, 16, number of 4-bit nibbles in the state (state width W = 4*NIBBLES)
LANES, 4, S-boxes evaluated per cycle; NIBBLES % LANES must be 0, otherwise elaboration fails
BEATS (localparam), NIBBLES/LANES, cycles per state; counter width CW = max(1, $clog2(BEATS))

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort: returns to IDLE and drops out_valid
in_valid  in  1  in_data/in_inv valid
in_ready  out  1  block can accept a state this cycle
in_data  in  W  input state; nibble 0 = bits [W-1:W-4] (MSB nibble)
in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled on accept only
out_valid  out  1  out_data holds a finished result
out_ready  in  1  downstream accepts out_data
out_data  out  W  substituted state, same nibble ordering as in_data

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, state register=0, beat counter=0, mode=0, out_valid=0, in_ready=1 after release, out_data=0. Reset mid-operation discards the in-flight state with no output.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (IDLE) or (DONE and out_ready). out_valid = (DONE).
- Accept = in_valid & in_ready: load in_data into the state register, latch in_inv, clear the counter, go to BUSY.
- BUSY, beat k (0..BEATS-1): replace nibbles k*LANES .. k*LANES+LANES-1 (nibble 0 first) with S(x) or S^-1(x). All other nibbles hold. The counter increments. On beat BEATS-1, go to DONE and do not wrap the counter.
- Latency: out_valid rises exactly BEATS cycles after the accept edge. With LANES=NIBBLES, out_valid rises 1 cycle after accept.
- DONE: out_data is stable while out_valid=1 and out_ready=0. If out_ready=1 and in_valid=0, go to IDLE. If out_ready=1 and in_valid=1, the output handoff and the new accept happen on the same edge, and the block goes straight to BUSY. Sustained throughput is therefore one state per BEATS+1 cycles.
- in_valid is ignored in BUSY. in_data/in_inv changes during BUSY have no effect.
- clear=1 has priority over every transition except reset. Next state is IDLE, out_valid=0, counter=0, and the state register holds its value. clear and in_valid in the same cycle: no accept.
- Forward S: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Inverse S^-1: 0..F -> 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- No arithmetic other than the counter. Nibble selection uses counter*LANES indexing into a W-bit vector and needs no overflow handling, given the divisibility check.

Decomposition:
- Shared package present_pkg: PRESENT_SBOX and PRESENT_SBOX_INV 16×4-bit constant tables, and the nibble width constant 4.
- Sub-module present_sbox_fi: one combinational nibble (a, inv -> y) reading both tables. Instantiate it LANES times via generate.
- Top level holds the FSM, counter, state register and lane mux/demux.

Test Plan:
- Default params, forward, in_data=0x0123456789ABCDEF -> out_data=0xC56B90AD3EF84712. out_valid rises 4 cycles after the accept edge.
- Inverse, in_data=0xC56B90AD3EF84712 -> out_data=0x0123456789ABCDEF. Forward in_data=0 -> 0xCCCCCCCCCCCCCCCC.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new state accepted on the same edge, no bubble beyond BEATS+1.
- Params LANES=16 and LANES=1 with the same vectors -> identical results, latency 1 and 16 cycles respectively.
- clear asserted on beat 2 -> IDLE next cycle, out_valid never rises. The next accepted state produces the correct result.
- rst_n pulsed low mid-BUSY (asynchronous, between edges) -> out_valid=0 and out_data=0 immediately. in_ready=1 after release.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT constants: forward/inverse 4-bit S-box tables, nibble width,
// and the state encoding of the iterative S-box layer.
package present_pkg;

    localparam int NIB_W = 4;

    localparam logic [NIB_W-1:0] PRESENT_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [NIB_W-1:0] PRESENT_SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sbox_state_e;

endpackage

// File: rtl/present_sbox_fi.sv
// One combinational PRESENT S-box nibble; inv selects the inverse table.
module present_sbox_fi
    import present_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic             inv,
    output logic [NIB_W-1:0] y
);

    assign y = inv ? PRESENT_SBOX_INV[a] : PRESENT_SBOX[a];

endmodule

// File: rtl/present_sbox_layer_seq.sv
// Iterative PRESENT S-box layer: LANES nibbles substituted per cycle, nibble 0
// (the MSB nibble) first, with valid/ready on both sides.
module present_sbox_layer_seq
    import present_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int LANES   = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4*NIBBLES-1:0]     in_data,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*NIBBLES-1:0]     out_data,
    output sbox_state_e              o_dbg_state
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int BEATS = NIBBLES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (NIBBLES % LANES != 0) begin : g_param_check
        $error("present_sbox_layer_seq: NIBBLES must be a multiple of LANES");
    end

    sbox_state_e       r_fsm;
    logic [W-1:0]      r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_inv;
    logic [W-1:0]      w_state_next;
    logic [NIB_W-1:0]  w_lane_out [LANES];
    logic              w_last_beat;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and data until that edge.
    assign in_ready    = (r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && out_ready);
    assign out_valid   = (r_fsm == ST_DONE);
    assign out_data    = r_state;
    assign o_dbg_state = r_fsm;
    assign w_last_beat = (r_cnt == CW'(BEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [NIB_W-1:0] w_in;
        logic [NIB_W-1:0] w_out;

        // Lane l handles nibble cnt*LANES + l of the current beat.
        always_comb begin
            w_in = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (r_cnt == CW'(b)) begin
                    w_in = r_state[(NIBBLES - 1 - (b * LANES + l)) * NIB_W +: NIB_W];
                end
            end
        end

        present_sbox_fi u_sbox (
            .a   (w_in),
            .inv (r_inv),
            .y   (w_out)
        );

        assign w_lane_out[l] = w_out;
    end

    always_comb begin
        w_state_next = r_state;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == CW'(i / LANES)) begin
                w_state_next[(NIBBLES - 1 - i) * NIB_W +: NIB_W] = w_lane_out[i % LANES];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
        end else if (clear) begin
            // Abort keeps the partially substituted state but drops the job.
            r_fsm <= ST_IDLE;
            r_cnt <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_inv   <= in_inv;
                        r_cnt   <= '0;
                        r_fsm   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_state <= w_state_next;
                    if (w_last_beat) begin
                        r_fsm <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            r_state <= in_data;
                            r_inv   <= in_inv;
                            r_cnt   <= '0;
                            r_fsm   <= ST_BUSY;
                        end else begin
                            r_fsm <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Bench for present_sbox_layer_seq: three lane configurations (4, 16, 1 lanes)
// driven from shared tasks and checked against a table-lookup reference.
module tb_present_sbox_layer_seq;
    import present_pkg::*;

    localparam int N = 16;
    localparam int W = 64;
    localparam int NINST = 3;
    localparam logic [63:0] FWD_TABLE = 64'hC56B90AD3EF84712;

    typedef struct {
        logic [W-1:0] data;
        logic         inv;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         clear     [NINST];
    logic         in_valid  [NINST];
    logic         in_ready  [NINST];
    logic [W-1:0] in_data   [NINST];
    logic         in_inv    [NINST];
    logic         out_valid [NINST];
    logic         out_ready [NINST];
    logic [W-1:0] out_data  [NINST];
    sbox_state_e  dbg_state [NINST];

    int beats_of [NINST] = '{4, 1, 16};
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    present_sbox_layer_seq #(.NIBBLES(N), .LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .o_dbg_state(dbg_state[0])
    );
    present_sbox_layer_seq #(.NIBBLES(N), .LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .o_dbg_state(dbg_state[1])
    );
    present_sbox_layer_seq #(.NIBBLES(N), .LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_data(in_data[2]), .in_inv(in_inv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .o_dbg_state(dbg_state[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] s_fwd(input logic [3:0] x);
        logic [63:0] t;
        t = FWD_TABLE;
        return t[(15 - int'(x)) * 4 +: 4];
    endfunction

    // Inverse found by searching the forward table for the preimage.
    function automatic logic [3:0] s_inv(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int j = 0; j < 16; j++) begin
            if (s_fwd(4'(j)) == x) r = 4'(j);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] model_layer(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int n = 0; n < N; n++) begin
            r[n * 4 +: 4] = inv ? s_inv(d[n * 4 +: 4]) : s_fwd(d[n * 4 +: 4]);
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_one(input int k, input logic [W-1:0] d, input logic inv,
                           input int stall, output logic [W-1:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_inv[k]   = inv;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = {$urandom, $urandom};
        in_inv[k]   = ~inv;
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (stall) @(negedge clk);
        res = out_data[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs [5];

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] held;
        logic [W-1:0] d;
        logic         inv;
        int           lat;
        int           bad;

        vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
        vecs[1] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
        vecs[4] = '{64'h0000000000000000, 1'b1, 64'h5555555555555555};

        rst_n = 1'b0;
        for (int k = 0; k < NINST; k++) begin
            clear[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0;
            in_inv[k] = 1'b0; out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NINST; k++) begin
            check($sformatf("reset_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
            check($sformatf("reset_in_ready[%0d]", k), 64'(in_ready[k]), 64'd1);
            check($sformatf("reset_out_data[%0d]", k), out_data[k], 64'd0);
        end

        // Table-driven vectors on every lane configuration.
        for (int k = 0; k < NINST; k++) begin
            for (int v = 0; v < 5; v++) begin
                run_one(k, vecs[v].data, vecs[v].inv, v % 3, res, lat);
                check($sformatf("vec%0d_data[%0d]", v, k), res, vecs[v].exp);
                check($sformatf("vec%0d_latency[%0d]", v, k), 64'(lat), 64'(beats_of[k]));
            end
        end

        // Backpressure then same-edge handoff/accept on the 4-lane instance.
        in_valid[0] = 1'b1; in_data[0] = vecs[0].data; in_inv[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        held = out_data[0];
        check("bp_first_result", held, vecs[0].exp);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_data[0] !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) bad++;
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        out_ready[0] = 1'b1; in_valid[0] = 1'b1;
        in_data[0] = vecs[1].data; in_inv[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0; in_valid[0] = 1'b0;
        check("bp_handoff_busy", 64'({out_valid[0], in_ready[0]}), 64'd0);
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_result", out_data[0], vecs[1].exp);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // clear on beat 2 together with in_valid: abort, no accept.
        in_valid[0] = 1'b1; in_data[0] = vecs[0].data; in_inv[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        clear[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = vecs[2].data;
        @(negedge clk);
        clear[0] = 1'b0; in_valid[0] = 1'b0;
        check("clear_idle_ready", 64'(in_ready[0]), 64'd1);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        check("clear_no_out_valid", 64'(bad), 64'd0);
        run_one(0, vecs[3].data, 1'b0, 0, res, lat);
        check("clear_next_result", res, vecs[3].exp);
        check("clear_next_latency", 64'(lat), 64'd4);

        // Asynchronous reset between edges while instances are busy.
        for (int k = 0; k < NINST; k++) begin
            in_valid[k] = 1'b1; in_data[k] = vecs[0].data; in_inv[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < NINST; k++) in_valid[k] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NINST; k++) begin
            check($sformatf("areset_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
            check($sformatf("areset_out_data[%0d]", k), out_data[k], 64'd0);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            check($sformatf("areset_in_ready[%0d]", k), 64'(in_ready[k]), 64'd1);
        end
        repeat (20) @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            check($sformatf("areset_no_output[%0d]", k), 64'(out_valid[k]), 64'd0);
        end

        // Randomized stimulus against the reference model.
        for (int k = 0; k < NINST; k++) begin
            for (int r = 0; r < 15; r++) begin
                d   = {$urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                exp_q.push_back(model_layer(d, inv));
                run_one(k, d, inv, $urandom_range(0, 3), res, lat);
                check($sformatf("rand%0d_data[%0d]", r, k), res, exp_q.pop_front());
                check($sformatf("rand%0d_latency[%0d]", r, k), 64'(lat), 64'(beats_of[k]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
